cnn_stream_feeder: RTL and testbench

- Host-side transmitter that drives the accelerator's byte-serial load interface (mode, din, ram_en) and collects its result bytes (dout, out_data_flag).
- Accepts weight and image bytes from an upstream valid/ready stream, paces them into the accelerator, and returns results on a result stream.
- Image data is buffered internally so the accelerator always receives one gap-free burst.

---
 rtl/cnn_stream_feeder_pkg.sv | 26 ++
 rtl/cnn_stream_feeder_if.sv | 28 ++
 rtl/cnn_stream_feeder_burst_buf.sv | 55 +++++
 rtl/cnn_stream_feeder.sv | 170 +++++++++++++++++
 tb/tb_cnn_stream_feeder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_stream_feeder_pkg.sv
// Shared types and sizes for the CNN stream feeder.
// Frame geometry, mode encoding and FSM states.
package cnn_stream_feeder_pkg;

    localparam int N_WEIGHT = 54;
    localparam int N_DATA   = 64;
    localparam int N_RESULT = 3;
    localparam int TIMEOUT  = 255;

    localparam logic MODE_WEIGHT = 1'b0;

    localparam int WCNT_W = $clog2(N_WEIGHT + 1);
    localparam int PTR_W  = $clog2(N_DATA);
    localparam int RCNT_W = $clog2(N_RESULT + 1);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WLOAD,
        DFILL,
        DBURST,
        WAIT_RES,
        DONE
    } state_e;

endpackage

// File: rtl/cnn_stream_feeder_if.sv
// Byte stream, accelerator load port and result stream.
// The feeder is the slave; host plus accelerator is the master.
interface cnn_stream_feeder_if;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       acc_mode;
    logic [7:0] acc_din;
    logic       acc_ram_en;
    logic [7:0] acc_dout;
    logic       acc_out_flag;
    logic       r_valid;
    logic [7:0] r_data;

    modport master (
        output s_valid, s_data, acc_dout, acc_out_flag,
        input  s_ready, acc_mode, acc_din, acc_ram_en,
        input  r_valid, r_data
    );

    modport slave (
        input  s_valid, s_data, acc_dout, acc_out_flag,
        output s_ready, acc_mode, acc_din, acc_ram_en,
        output r_valid, r_data
    );

endinterface

// File: rtl/cnn_stream_feeder_burst_buf.sv
// Image staging buffer: filled at host pace, drained
// back-to-back so the accelerator sees one gap-free burst.
module feeder_burst_buf
    import cnn_stream_feeder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       wr_last_o,
    output logic       rd_last_o,
    output logic       full_o
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(N_DATA - 1);

    logic [7:0]       mem_q [N_DATA];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             full_q;

    assign wr_last_o = (wr_ptr_q == LAST);
    assign rd_last_o = (rd_ptr_q == LAST);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = full_q;

    // Storage, pointers and full flag; pointers wrap after one frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DATA; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q <= wr_last_o ? '0 : wr_ptr_q + PTR_W'(1);
                if (wr_last_o) begin
                    full_q <= 1'b1;
                end
            end
            if (rd_en_i) begin
                rd_ptr_q <= rd_last_o ? '0 : rd_ptr_q + PTR_W'(1);
                if (rd_last_o) begin
                    full_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/cnn_stream_feeder.sv
// Host-side feeder: paces weights, stages and bursts image
// bytes into the accelerator, then collects result bytes.
module cnn_stream_feeder
    import cnn_stream_feeder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                skip_weights,
    cnn_stream_feeder_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                err_timeout
);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                mode_q, mode_d;
    logic                ram_en_q, ram_en_d;
    logic [7:0]          din_q, din_d;
    logic                r_valid_q, r_valid_d;
    logic [7:0]          r_data_q, r_data_d;
    logic                err_q, err_d;

    logic                hs;
    logic                buf_wr;
    logic                buf_rd;
    logic                wr_last;
    logic                rd_last;
    logic                buf_full;
    logic [7:0]          buf_rdata;

    assign bus.s_ready = (state_q == WLOAD) || (state_q == DFILL);
    assign hs          = bus.s_valid && bus.s_ready;
    assign buf_wr      = hs && (state_q == DFILL);
    assign buf_rd      = (state_q == DBURST) && buf_full;

    assign bus.acc_mode   = mode_q;
    assign bus.acc_din    = din_q;
    assign bus.acc_ram_en = ram_en_q;
    assign bus.r_valid    = r_valid_q;
    assign bus.r_data     = r_data_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign err_timeout    = err_q;

    feeder_burst_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (buf_wr),
        .wr_data_i (bus.s_data),
        .rd_en_i   (buf_rd),
        .rd_data_o (buf_rdata),
        .wr_last_o (wr_last),
        .rd_last_o (rd_last),
        .full_o    (buf_full)
    );

    // Next state, counters and registered accelerator/result outputs.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        tcnt_d    = tcnt_q;
        mode_d    = MODE_WEIGHT;
        ram_en_d  = 1'b0;
        din_d     = din_q;
        r_valid_d = 1'b0;
        r_data_d  = r_data_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                    tcnt_d  = '0;
                    state_d = skip_weights ? DFILL : WLOAD;
                end
            end
            WLOAD: begin
                if (hs) begin
                    din_d    = bus.s_data;
                    ram_en_d = 1'b1;
                    if (wcnt_q == WCNT_W'(N_WEIGHT - 1)) begin
                        wcnt_d  = '0;
                        state_d = DFILL;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            DFILL: begin
                if (hs && wr_last) begin
                    state_d = DBURST;
                end
            end
            DBURST: begin
                if (buf_rd) begin
                    din_d    = buf_rdata;
                    ram_en_d = 1'b1;
                    mode_d   = ~MODE_WEIGHT;
                    if (rd_last) begin
                        tcnt_d  = '0;
                        state_d = WAIT_RES;
                    end
                end
            end
            WAIT_RES: begin
                if (bus.acc_out_flag) begin
                    r_valid_d = 1'b1;
                    r_data_d  = bus.acc_dout;
                    tcnt_d    = '0;
                    rcnt_d    = rcnt_q + RCNT_W'(1);
                    if (rcnt_q == RCNT_W'(N_RESULT - 1)) begin
                        state_d = DONE;
                    end
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q    <= '0;
            rcnt_q    <= '0;
            tcnt_q    <= '0;
            mode_q    <= MODE_WEIGHT;
            ram_en_q  <= 1'b0;
            din_q     <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            tcnt_q    <= tcnt_d;
            mode_q    <= mode_d;
            ram_en_q  <= ram_en_d;
            din_q     <= din_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_cnn_stream_feeder.sv
// Bench for cnn_stream_feeder: frame scenarios from a table,
// checked against a byte-order / result-timing reference model.
module tb_cnn_stream_feeder;
    import cnn_stream_feeder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic skip_weights;
    logic busy;
    logic done;
    logic err_timeout;

    int tests = 0;
    int fails = 0;

    cnn_stream_feeder_if bus ();

    cnn_stream_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .skip_weights (skip_weights),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit skip;
        int gap;
        int fmode;
        bit disturb;
        bit exp_to;
        int exp_nres;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input bit ok, input string name,
                         input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int out_vec();
        return int'({busy, done, err_timeout, bus.s_ready,
                     bus.acc_ram_en, bus.acc_din, bus.acc_mode,
                     bus.r_valid, bus.r_data});
    endfunction

    function automatic int rst_vec();
        logic [22:0] v;
        v = {5'b0, 8'h00, MODE_WEIGHT, 1'b0, 8'h00};
        return int'(v);
    endfunction

    // fmode: 0 no flag, 1 three flags plus two extra,
    // 2 randomly spaced flags, 3 one flag then silence
    task automatic run_frame(input vec_t v, input string tag);
        logic [7:0] bytes [$];
        logic [8:0] exp_w [$];
        logic [8:0] got_w [$];
        logic [7:0] exp_r [$];
        logic [7:0] got_r [$];
        int         burst_cyc [$];
        logic [7:0] dout;
        int nw, total, idx, cyc, wcyc, gap_cnt, nflag, next_at;
        int exp_done, done_cyc, done_cnt, tail, bad;
        bit pv, pr, fixed, exp_err, err_at_done, seen, flag, ok;

        nw = v.skip ? 0 : N_WEIGHT;
        total = nw + N_DATA;
        idx = 0; cyc = 0; wcyc = 0; gap_cnt = 0; nflag = 0;
        exp_done = -1; done_cyc = -1; done_cnt = 0; tail = 0;
        pv = 0; pr = 0; fixed = 0; exp_err = 0;
        err_at_done = 0; seen = 0;
        next_at = $urandom_range(40, 1);
        for (int i = 0; i < total; i++) begin
            logic [7:0] b;
            b = (v.gap == 0 && !v.skip) ? 8'(i) : 8'($urandom);
            bytes.push_back(b);
            exp_w.push_back({(i < nw) ? MODE_WEIGHT : ~MODE_WEIGHT, b});
        end

        @(negedge clk);
        start = 1'b1;
        skip_weights = v.skip;
        @(negedge clk);
        start = 1'b0;
        check(busy && !err_timeout, {tag, " busy_and_err_cleared"},
              int'({busy, err_timeout}), 2);

        while (tail < 4 && cyc < 3000) begin
            if (cyc != 0) @(negedge clk);
            cyc++;
            if (bus.acc_ram_en) begin
                got_w.push_back({bus.acc_mode, bus.acc_din});
                if (bus.acc_mode != MODE_WEIGHT)
                    burst_cyc.push_back(cyc);
            end
            if (bus.r_valid) got_r.push_back(bus.r_data);
            if (done) begin
                done_cnt++;
                if (!seen) begin
                    seen = 1;
                    done_cyc = cyc;
                    err_at_done = err_timeout;
                end
            end
            if (seen) tail++;
            if (pv && pr) idx++;

            pr = bus.s_ready;
            bus.s_valid = (idx < total) &&
                          ($urandom_range(99, 0) >= v.gap);
            bus.s_data = (idx < total) ? bytes[idx] : 8'h00;
            pv = bus.s_valid;
            start = v.disturb && burst_cyc.size() == 10;

            dout = 8'($urandom);
            flag = 0;
            if (v.disturb && pr && idx >= nw && idx < total &&
                (idx % 5) == 2)
                flag = 1;
            if (burst_cyc.size() == N_DATA && !fixed) begin
                wcyc++;
                case (v.fmode)
                    1: flag = 1;
                    2: flag = (wcyc >= next_at);
                    3: flag = (wcyc == 3);
                    default: flag = 0;
                endcase
                if (flag) begin
                    exp_r.push_back(dout);
                    nflag++;
                    gap_cnt = 0;
                    next_at = wcyc + $urandom_range(40, 1);
                    if (exp_r.size() == N_RESULT) begin
                        fixed = 1;
                        exp_done = cyc + 1;
                    end
                end else begin
                    gap_cnt++;
                    if (gap_cnt == TIMEOUT) begin
                        fixed = 1;
                        exp_err = 1;
                        exp_done = cyc + 1;
                    end
                end
            end else if (fixed && v.fmode == 1 && nflag < 5) begin
                flag = 1;
                nflag++;
            end
            bus.acc_out_flag = flag;
            bus.acc_dout = dout;
        end
        bus.s_valid = 1'b0;
        bus.acc_out_flag = 1'b0;
        start = 1'b0;

        check(seen, {tag, " done_seen"}, int'(seen), 1);

        bad = -1;
        for (int i = 0; i < exp_w.size(); i++)
            if (bad < 0 && (i >= got_w.size() || got_w[i] !== exp_w[i]))
                bad = i;
        if (bad < 0 && got_w.size() != exp_w.size()) bad = exp_w.size();
        check(bad < 0, {tag, " acc_writes first_bad_index"}, bad, -1);

        ok = burst_cyc.size() == N_DATA;
        bad = 0;
        if (burst_cyc.size() > 0)
            bad = burst_cyc[burst_cyc.size() - 1] - burst_cyc[0] + 1;
        check(ok && bad == N_DATA, {tag, " burst_span_cycles"},
              bad, N_DATA);

        bad = -1;
        for (int i = 0; i < exp_r.size(); i++)
            if (bad < 0 && (i >= got_r.size() || got_r[i] !== exp_r[i]))
                bad = i;
        check(bad < 0, {tag, " result_bytes first_bad_index"}, bad, -1);
        check(got_r.size() == v.exp_nres, {tag, " result_count"},
              got_r.size(), v.exp_nres);
        check(done_cyc == exp_done && done_cnt == 1,
              {tag, " done_cycle"}, done_cyc, exp_done);
        check(err_at_done == v.exp_to && err_at_done == exp_err,
              {tag, " err_timeout"}, int'(err_at_done), int'(v.exp_to));
        check(!busy, {tag, " idle_after_done"}, int'(busy), 0);
    endtask

    vec_t post;
    int   n;
    bit   rdy;

    initial begin
        vecs[0] = '{0, 0, 1, 0, 0, 3};
        vecs[1] = '{0, 40, 2, 0, 0, 3};
        vecs[2] = '{1, 30, 1, 0, 0, 3};
        vecs[3] = '{1, 0, 0, 0, 1, 0};
        vecs[4] = '{0, 20, 2, 1, 0, 3};
        vecs[5] = '{1, 50, 3, 0, 1, 1};
        post    = '{1, 0, 1, 0, 0, 3};

        rst_n = 1'b0;
        start = 1'b0;
        skip_weights = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        bus.acc_dout = 8'h00;
        bus.acc_out_flag = 1'b0;
        repeat (3) @(negedge clk);
        check(out_vec() == rst_vec(), "reset_outputs",
              out_vec(), rst_vec());
        rst_n = 1'b1;

        for (int f = 0; f < 6; f++)
            run_frame(vecs[f], $sformatf("frame%0d", f));

        @(negedge clk);
        start = 1'b1;
        skip_weights = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int k = 0; k < 200 && n < 32; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data = 8'(100 + n);
            rdy = bus.s_ready;
            @(negedge clk);
            if (rdy) n++;
        end
        check(n == 32, "dfill_bytes_before_reset", n, 32);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check(out_vec() == rst_vec(), "reset_mid_dfill",
              out_vec(), rst_vec());
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(post, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
